// File: rtl/mac_operand_sequencer_if.sv
// Operand/SRAM/MAC signal bundle for one mac_operand_sequencer lane.
// The master modport is the sequencer side; the slave modport is the controller, SRAMs and MAC.
interface mac_operand_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
);
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic [ADDR_W-1:0] cfg_ifmap_base;
  logic [ADDR_W-1:0] cfg_weight_base;
  logic [ADDR_W-1:0] cfg_stride;

  logic              ifmap_rd_en;
  logic [ADDR_W-1:0] ifmap_addr;
  logic [DATA_W-1:0] ifmap_rdata;
  logic              weight_rd_en;
  logic [ADDR_W-1:0] weight_addr;
  logic [DATA_W-1:0] weight_rdata;

  logic [DATA_W-1:0] mac_ifmap;
  logic [DATA_W-1:0] mac_weights;
  logic              mac_en;
  logic              mac_lastdata;
  logic              mac_reset;
  logic [DATA_W-1:0] mac_accumulation;

  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    input  start, cfg_len, cfg_ifmap_base, cfg_weight_base, cfg_stride,
    input  ifmap_rdata, weight_rdata, mac_accumulation,
    output ifmap_rd_en, ifmap_addr, weight_rd_en, weight_addr,
    output mac_ifmap, mac_weights, mac_en, mac_lastdata, mac_reset,
    output busy, done, result
  );

  modport slave (
    output start, cfg_len, cfg_ifmap_base, cfg_weight_base, cfg_stride,
    output ifmap_rdata, weight_rdata, mac_accumulation,
    input  ifmap_rd_en, ifmap_addr, weight_rd_en, weight_addr,
    input  mac_ifmap, mac_weights, mac_en, mac_lastdata, mac_reset,
    input  busy, done, result
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Sequences one dot product: clears the MAC, streams N operand pairs from two
// 1-cycle-latency SRAMs, flags the last pair, then captures the accumulation.
module mac_operand_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic clk,
  input  logic reset,
  mac_operand_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    CAPTURE,
    CAPTURE_ZERO
  } state_t;

  state_t            state_reg, state_next;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] stride_reg;
  logic              mac_en_reg;
  logic              last_reg;
  logic              done_reg;
  logic [DATA_W-1:0] result_reg;

  logic accept;
  logic issue;
  logic last_pair;

  assign accept    = (state_reg == IDLE) && bus.start;
  assign issue     = (state_reg == ISSUE);
  assign last_pair = (cnt_reg == len_reg - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.cfg_len == '0) ? CAPTURE_ZERO : CLEAR;
        end
      end
      CLEAR:        state_next = ISSUE;
      ISSUE:        if (last_pair) state_next = DRAIN;
      DRAIN:        state_next = CAPTURE;
      CAPTURE:      state_next = IDLE;
      CAPTURE_ZERO: state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  // One running-sum address generator per stream; both share the latched stride.
  for (genvar gi = 0; gi < 2; gi++) begin : g_addr
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr_reg;

    assign base = (gi == 0) ? bus.cfg_ifmap_base : bus.cfg_weight_base;

    always_ff @(posedge clk) begin
      if (reset) begin
        addr_reg <= '0;
      end else if (accept) begin
        addr_reg <= base;
      end else if (issue) begin
        addr_reg <= addr_reg + stride_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_reg    <= '0;
      cnt_reg    <= '0;
      stride_reg <= '0;
      mac_en_reg <= 1'b0;
      last_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
    end else begin
      // MAC strobes trail the read strobes by the SRAM read latency.
      mac_en_reg <= issue;
      last_reg   <= issue && last_pair;
      done_reg   <= 1'b0;
      if (accept) begin
        len_reg    <= bus.cfg_len;
        stride_reg <= bus.cfg_stride;
        cnt_reg    <= '0;
      end
      if (issue) begin
        cnt_reg <= cnt_reg + LEN_W'(1);
      end
      if (state_reg == CAPTURE) begin
        result_reg <= bus.mac_accumulation;
        done_reg   <= 1'b1;
      end
      if (state_reg == CAPTURE_ZERO) begin
        result_reg <= '0;
        done_reg   <= 1'b1;
      end
    end
  end

  assign bus.ifmap_rd_en  = issue;
  assign bus.weight_rd_en = issue;
  assign bus.ifmap_addr   = g_addr[0].addr_reg;
  assign bus.weight_addr  = g_addr[1].addr_reg;

  assign bus.mac_ifmap    = bus.ifmap_rdata;
  assign bus.mac_weights  = bus.weight_rdata;
  assign bus.mac_en       = mac_en_reg;
  assign bus.mac_lastdata = last_reg;
  assign bus.mac_reset    = reset || (state_reg == CLEAR);

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = done_reg;
  assign bus.result = result_reg;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: SRAM and MAC models around the DUT, a directed
// table, hand-written abort/back-to-back sequences and randomized jobs vs a dot-product model.
module tb_mac_operand_sequencer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int LEN_W  = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;

  mac_operand_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  mac_operand_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] imem [DEPTH];
  logic [DATA_W-1:0] wmem [DEPTH];
  logic [DATA_W-1:0] irdata_q, wrdata_q, acc_q;

  always @(posedge clk) begin
    if (bus.ifmap_rd_en)  irdata_q <= imem[bus.ifmap_addr];
    if (bus.weight_rd_en) wrdata_q <= wmem[bus.weight_addr];
    if (bus.mac_reset)    acc_q <= '0;
    else if (bus.mac_en)  acc_q <= acc_q + bus.mac_ifmap * bus.mac_weights;
  end

  assign bus.ifmap_rdata      = irdata_q;
  assign bus.weight_rdata     = wrdata_q;
  assign bus.mac_accumulation = acc_q;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int wrap_addr(input int base, input int k, input int st);
    return (base + k * st) % DEPTH;
  endfunction

  // Reference: plain dot product over the strided address sequences, mod 2^32.
  function automatic logic [31:0] dot_model(input int len, input int ib, input int wb, input int st);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < len; k++) begin
      s += imem[wrap_addr(ib, k, st)] * wmem[wrap_addr(wb, k, st)];
    end
    return s;
  endfunction

  // Entered and left at a negedge; the caller may chain jobs with no gap.
  task automatic run_job(input string nm, input int len, input int ib, input int wb,
                         input int st, input logic [31:0] exp, input bit poke);
    int rd_cnt, en_cnt, last_cnt, done_c, exp_lat;
    rd_cnt = 0; en_cnt = 0; last_cnt = 0; done_c = 0;
    exp_lat = (len == 0) ? 2 : len + 4;
    bus.start           = 1'b1;
    bus.cfg_len         = LEN_W'(len);
    bus.cfg_ifmap_base  = ADDR_W'(ib);
    bus.cfg_weight_base = ADDR_W'(wb);
    bus.cfg_stride      = ADDR_W'(st);
    @(posedge clk);
    for (int c = 1; c <= len + 8 && done_c == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start      = 1'b0;
        bus.cfg_len    = LEN_W'(len + 5);
        bus.cfg_stride = ADDR_W'(st + 7);
        check({nm, " mac_reset_T1"}, 32'(bus.mac_reset), 32'(len != 0));
        check({nm, " busy_T1"}, 32'(bus.busy), 32'd1);
      end
      if (poke && c == 3) begin
        bus.start   = 1'b1;
        bus.cfg_len = LEN_W'(1);
      end
      if (poke && c == 4) bus.start = 1'b0;
      check({nm, " rd_en_pair"}, 32'(bus.weight_rd_en), 32'(bus.ifmap_rd_en));
      if (bus.ifmap_rd_en) begin
        check({nm, " rd_cycle"}, 32'(c), 32'(rd_cnt + 2));
        check({nm, " ifmap_addr"}, 32'(bus.ifmap_addr), 32'(wrap_addr(ib, rd_cnt, st)));
        check({nm, " weight_addr"}, 32'(bus.weight_addr), 32'(wrap_addr(wb, rd_cnt, st)));
        rd_cnt++;
      end
      if (bus.mac_en) begin
        check({nm, " en_cycle"}, 32'(c), 32'(en_cnt + 3));
        check({nm, " mac_ifmap"}, bus.mac_ifmap, imem[wrap_addr(ib, en_cnt, st)]);
        check({nm, " mac_weights"}, bus.mac_weights, wmem[wrap_addr(wb, en_cnt, st)]);
        en_cnt++;
      end
      if (bus.mac_lastdata) begin
        last_cnt++;
        check({nm, " last_cycle"}, 32'(c), 32'(len + 2));
        check({nm, " last_with_en"}, 32'(bus.mac_en), 32'd1);
      end
      if (bus.done) done_c = c;
    end
    check({nm, " done_cycle"}, 32'(done_c), 32'(exp_lat));
    check({nm, " result"}, bus.result, exp);
    check({nm, " busy_at_done"}, 32'(bus.busy), 32'd0);
    check({nm, " rd_count"}, 32'(rd_cnt), 32'(len));
    check({nm, " en_count"}, 32'(en_cnt), 32'(len));
    check({nm, " last_count"}, 32'(last_cnt), 32'(len != 0));
    $display("job %s: len=%0d ib=%0h wb=%0h st=%0h result=%0h done@T%0d", nm, len, ib, wb, st,
             bus.result, done_c);
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, " ifmap_rd_en"}, 32'(bus.ifmap_rd_en), 32'd0);
    check({nm, " weight_rd_en"}, 32'(bus.weight_rd_en), 32'd0);
    check({nm, " mac_en"}, 32'(bus.mac_en), 32'd0);
    check({nm, " mac_lastdata"}, 32'(bus.mac_lastdata), 32'd0);
    check({nm, " busy"}, 32'(bus.busy), 32'd0);
    check({nm, " done"}, 32'(bus.done), 32'd0);
    check({nm, " ifmap_addr"}, 32'(bus.ifmap_addr), 32'd0);
    check({nm, " weight_addr"}, 32'(bus.weight_addr), 32'd0);
    check({nm, " result"}, bus.result, 32'd0);
  endtask

  typedef struct {
    int          len;
    int          ib;
    int          wb;
    int          st;
    logic [31:0] exp;
    bit          chain;
    bit          poke;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int dones;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cfg_len = '0;
    bus.cfg_ifmap_base = '0;
    bus.cfg_weight_base = '0;
    bus.cfg_stride = '0;
    for (int a = 0; a < DEPTH; a++) begin
      imem[a] = '0;
      wmem[a] = '0;
    end
    for (int a = 0; a < 4; a++) begin
      imem[a]         = 32'(a + 1);
      wmem['h100 + a] = 32'(a + 5);
    end
    imem['h10] = 32'h0001_0000;  wmem['h110] = 32'h0001_0000;
    imem['h3FE] = 2;  imem['h3FF] = 3;
    wmem['h3FE] = 10; wmem['h3FF] = 20; wmem[0] = 100;
    imem['h40] = 7;   imem['h45] = 9;   wmem['h140] = 11; wmem['h145] = 13;
    imem['h20] = 3;   imem['h21] = 3;   wmem['h120] = 2;  wmem['h121] = 2;
    for (int a = 'h30; a < 'h38; a++) begin
      imem[a] = 32'($urandom_range(1, 1000));
      wmem['h100 + a] = 32'($urandom_range(1, 1000));
    end

    tbl[0] = '{4, 'h000, 'h100, 1, 32'd70,  1'b0, 1'b0};
    tbl[1] = '{1, 'h010, 'h110, 1, 32'd0,   1'b0, 1'b0};
    tbl[2] = '{0, 'h055, 'h066, 3, 32'd0,   1'b0, 1'b0};
    tbl[3] = '{3, 'h3FE, 'h3FE, 1, 32'd180, 1'b1, 1'b1};
    tbl[4] = '{2, 'h040, 'h140, 5, 32'd194, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    check("reset mac_reset", 32'(bus.mac_reset), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("idle mac_reset", 32'(bus.mac_reset), 32'd0);
    check("idle busy", 32'(bus.busy), 32'd0);

    for (int v = 0; v < 5; v++) begin
      if (!tbl[v].chain) repeat (2) @(negedge clk);
      run_job($sformatf("vec%0d", v), tbl[v].len, tbl[v].ib, tbl[v].wb, tbl[v].st,
              tbl[v].exp, tbl[v].poke);
    end

    // Abort a job in the middle of its read burst.
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.cfg_len = LEN_W'(8);
    bus.cfg_ifmap_base = ADDR_W'('h30);
    bus.cfg_weight_base = ADDR_W'('h130);
    bus.cfg_stride = ADDR_W'(1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort in_issue", 32'(bus.ifmap_rd_en), 32'd1);
    reset = 1'b1;
    #1;
    check("abort mac_reset", 32'(bus.mac_reset), 32'd1);
    @(negedge clk);
    check_reset_values("abort");
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("abort no_done", 32'(dones), 32'd0);
    $display("job abort: reset mid-issue, idle cycles with activity=%0d", dones);
    run_job("after_abort", 2, 'h20, 'h120, 1, 32'd12, 1'b0);

    for (int a = 0; a < DEPTH; a++) begin
      imem[a] = $urandom;
      wmem[a] = $urandom;
    end
    for (int r = 0; r < 16; r++) begin
      int len, ib, wb, st;
      bit poke;
      len = $urandom_range(0, 20);
      ib  = $urandom_range(0, DEPTH - 1);
      wb  = $urandom_range(0, DEPTH - 1);
      st  = $urandom_range(0, DEPTH - 1);
      poke = (len >= 2) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_job($sformatf("rand%0d", r), len, ib, wb, st, dot_model(len, ib, wb, st), poke);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
